dcache_port_arbiter: RTL



---
 rtl/dcache_port_arbiter_if.sv | 49 ++++
 rtl/dcache_port_arbiter.sv | 132 +++++++++++++
 2 files changed

// File: rtl/dcache_port_arbiter_if.sv
// dcache_port_arbiter_if: requester and D$ signals of the shared D$ port.
// slave = arbiter side, master = requesters / D$ / environment side.
interface dcache_port_arbiter_if;
    logic        s_req_i;
    logic        s_we_i;
    logic [31:0] s_addr_i;
    logic [31:0] s_wdata_i;
    logic [3:0]  s_strb_i;
    logic        s_wait_o;
    logic [31:0] s_rdata_o;

    logic        v_req_i;
    logic        v_we_i;
    logic [31:0] v_addr_i;
    logic [31:0] v_wdata_i;
    logic [3:0]  v_strb_i;
    logic        v_wait_o;
    logic [31:0] v_rdata_o;

    logic        d_req_o;
    logic        d_we_o;
    logic [31:0] d_addr_o;
    logic [31:0] d_wdata_o;
    logic [3:0]  d_strb_o;
    logic        d_wait_i;
    logic [31:0] d_rdata_i;

    logic [1:0]  owner_o;

    modport slave (
        input  s_req_i, s_we_i, s_addr_i, s_wdata_i, s_strb_i,
        output s_wait_o, s_rdata_o,
        input  v_req_i, v_we_i, v_addr_i, v_wdata_i, v_strb_i,
        output v_wait_o, v_rdata_o,
        output d_req_o, d_we_o, d_addr_o, d_wdata_o, d_strb_o,
        input  d_wait_i, d_rdata_i,
        output owner_o
    );

    modport master (
        output s_req_i, s_we_i, s_addr_i, s_wdata_i, s_strb_i,
        input  s_wait_o, s_rdata_o,
        output v_req_i, v_we_i, v_addr_i, v_wdata_i, v_strb_i,
        input  v_wait_o, v_rdata_o,
        input  d_req_o, d_we_o, d_addr_o, d_wdata_o, d_strb_o,
        output d_wait_i, d_rdata_i,
        input  owner_o
    );
endinterface

// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter: shares the D$ core port between scalar MEM and VPU LSU.
// Ports: clk_i, rst_i (sync, active-high), bus (dcache_port_arbiter_if.slave).
// Define DCACHE_ARB_RR_EN for round-robin ties instead of the starve guard.
module dcache_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    dcache_port_arbiter_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_S = 2'd1,
        BUSY_V = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic        grant_s, grant_v;
    logic        arb;

`ifdef DCACHE_ARB_RR_EN
    // 1 = vector took the last grant, so scalar owns the next tie.
    logic        last_v_q;
`else
    logic [3:0]  starve_q;
`endif

    assign arb = (state_q == IDLE);

    always_comb begin
        grant_s = 1'b0;
        grant_v = 1'b0;
`ifdef DCACHE_ARB_RR_EN
        grant_v = bus.v_req_i & (~bus.s_req_i | ~last_v_q);
`else
        grant_v = bus.v_req_i &
                  (~bus.s_req_i | (starve_q == 4'(STARVE_LIMIT)));
`endif
        grant_s = bus.s_req_i & ~grant_v;
    end

    always_comb begin
        state_d       = state_q;
        bus.d_req_o   = 1'b0;
        bus.s_wait_o  = bus.s_req_i;
        bus.v_wait_o  = bus.v_req_i;
        bus.s_rdata_o = '0;
        bus.v_rdata_o = '0;
        unique case (state_q)
            IDLE: begin
                if (grant_s)      state_d = BUSY_S;
                else if (grant_v) state_d = BUSY_V;
            end
            BUSY_S: begin
                bus.d_req_o   = 1'b1;
                bus.s_wait_o  = bus.d_wait_i;
                bus.s_rdata_o = bus.d_rdata_i;
                if (!bus.d_wait_i)      state_d = IDLE;
                else if (!bus.s_req_i)  state_d = DRAIN;
            end
            BUSY_V: begin
                bus.d_req_o   = 1'b1;
                bus.v_wait_o  = bus.d_wait_i;
                bus.v_rdata_o = bus.d_rdata_i;
                if (!bus.d_wait_i)      state_d = IDLE;
                else if (!bus.v_req_i)  state_d = DRAIN;
            end
            DRAIN: begin
                // Flushed owner: finish the D$ access, discard its data.
                bus.d_req_o = 1'b1;
                if (!bus.d_wait_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Payload comes only from the latched copy, never from live inputs.
    assign bus.d_we_o    = we_q;
    assign bus.d_addr_o  = addr_q;
    assign bus.d_wdata_o = wdata_q;
    assign bus.d_strb_o  = strb_q;
    assign bus.owner_o   = state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else begin
            state_q <= state_d;
            if (arb && grant_s) begin
                we_q    <= bus.s_we_i;
                addr_q  <= bus.s_addr_i;
                wdata_q <= bus.s_wdata_i;
                strb_q  <= bus.s_strb_i;
            end else if (arb && grant_v) begin
                we_q    <= bus.v_we_i;
                addr_q  <= bus.v_addr_i;
                wdata_q <= bus.v_wdata_i;
                strb_q  <= bus.v_strb_i;
            end
        end
    end

`ifdef DCACHE_ARB_RR_EN
    always_ff @(posedge clk_i) begin
        if (rst_i)                    last_v_q <= 1'b1;
        else if (arb && grant_v)      last_v_q <= 1'b1;
        else if (arb && grant_s)      last_v_q <= 1'b0;
    end
`else
    // Counts ties lost by vector; single-requester scalar grants leave it.
    always_ff @(posedge clk_i) begin
        if (rst_i)
            starve_q <= '0;
        else if (arb && grant_v)
            starve_q <= '0;
        else if (arb && grant_s && bus.v_req_i &&
                 starve_q != 4'(STARVE_LIMIT))
            starve_q <= starve_q + 4'd1;
    end
`endif

endmodule
